// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer.
// Drives datapath strobes, mux selects and a memory req/ack handshake.
module mips_mc_sequencer #(
   parameter int OPCODE_WIDTH = 6,
   parameter int ALUOP_WIDTH  = 2,
   parameter int TO_WIDTH     = 4,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   input  logic                    mem_ack,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic                    iord,
   output logic                    ir_we,
   output logic                    pc_we,
   output logic [1:0]              pc_src,
   output logic                    reg_we,
   output logic                    reg_dst,
   output logic                    mem_to_reg,
   output logic                    alu_src_a,
   output logic [1:0]              alu_src_b,
   output logic [ALUOP_WIDTH-1:0]  alu_op,
   output logic                    instr_done,
   output logic                    fault,
   output logic [3:0]              state
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_RWB    = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JUMP   = 4'd10;
   localparam logic [3:0] S_IMMEX  = 4'd11;
   localparam logic [3:0] S_IMMWB  = 4'd12;
   localparam logic [3:0] S_FAULT  = 4'd15;

   localparam logic [OPCODE_WIDTH-1:0] OP_R    =
      OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW   =
      OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW   =
      OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  =
      OPCODE_WIDTH'(6'b000100);
   localparam logic [OPCODE_WIDTH-1:0] OP_J    =
      OPCODE_WIDTH'(6'b000010);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI =
      OPCODE_WIDTH'(6'b001000);

   localparam logic [ALUOP_WIDTH-1:0] ALU_ADD =
      ALUOP_WIDTH'(2'b00);
   localparam logic [ALUOP_WIDTH-1:0] ALU_SUB =
      ALUOP_WIDTH'(2'b01);
   localparam logic [ALUOP_WIDTH-1:0] ALU_FN  =
      ALUOP_WIDTH'(2'b10);

   localparam logic [TO_WIDTH-1:0] TO_LAST =
      TO_WIDTH'(MEM_TIMEOUT - 1);

   logic [3:0]          state_q;
   logic [3:0]          state_d;
   logic [TO_WIDTH-1:0] timeout_q;
   logic [TO_WIDTH-1:0] timeout_d;
   logic                ack_pend_q;
   logic                ack_pend_d;

   logic in_mem;
   logic ack_hit;
   logic to_hit;

   logic is_r;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_j;
   logic is_addi;

   assign is_r    = (opcode == OP_R);
   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_j    = (opcode == OP_J);
   assign is_addi = (opcode == OP_ADDI);

   assign in_mem = (state_q == S_FETCH) |
                   (state_q == S_MEMRD) |
                   (state_q == S_MEMWR);

   // An ack seen during a freeze is replayed on the next enabled cycle.
   assign ack_hit = en & in_mem & (mem_ack | ack_pend_q);

   // Ack on the final allowed wait cycle takes priority over the timeout.
   assign to_hit = en & in_mem & ~ack_hit &
                   (timeout_q == TO_LAST);

   assign state = state_q;

   // Next-state sequencing; nothing moves while en is low.
   always_comb begin
      state_d = state_q;
      if (en) begin
         case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
               if (ack_hit)
                  state_d = S_DECODE;
               else if (to_hit)
                  state_d = S_FAULT;
            end
            S_DECODE: begin
               unique case (1'b1)
                  is_r:            state_d = S_EXEC;
                  is_lw || is_sw:  state_d = S_MEMADR;
                  is_beq:          state_d = S_BRANCH;
                  is_j:            state_d = S_JUMP;
                  is_addi:         state_d = S_IMMEX;
                  default:         state_d = S_FAULT;
               endcase
            end
            S_MEMADR:
               state_d = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
               if (ack_hit)
                  state_d = S_MEMWB;
               else if (to_hit)
                  state_d = S_FAULT;
            end
            S_MEMWR: begin
               if (ack_hit)
                  state_d = S_FETCH;
               else if (to_hit)
                  state_d = S_FAULT;
            end
            S_EXEC:   state_d = S_RWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB,
            S_RWB,
            S_BRANCH,
            S_JUMP,
            S_IMMWB:  state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
         endcase
      end
   end

   // Wait counter restarts on every state change, counts enabled stalls.
   always_comb begin
      timeout_d = timeout_q;
      if (en) begin
         if (state_d != state_q)
            timeout_d = '0;
         else if (in_mem)
            timeout_d = timeout_q + 1'b1;
      end
   end

   // Remember an ack that lands while frozen in a memory state.
   always_comb begin
      if (en)
         ack_pend_d = 1'b0;
      else
         ack_pend_d = ack_pend_q | (mem_ack & in_mem);
   end

   // Moore selects plus en-gated strobes decoded from the current state.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
      fault      = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_we     = ack_hit;
            pc_we     = ack_hit;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_we     = en;
            mem_to_reg = 1'b1;
            instr_done = en;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            mem_we     = 1'b1;
            instr_done = ack_hit;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FN;
         end
         S_RWB: begin
            reg_we     = en;
            reg_dst    = 1'b1;
            instr_done = en;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_SUB;
            pc_src     = 2'b01;
            pc_we      = en & zero;
            instr_done = en;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_we      = en;
            instr_done = en;
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_IMMWB: begin
            reg_we     = en;
            instr_done = en;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            fault = 1'b0;
         end
      endcase
   end

   // State, wait counter and pending-ack registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         timeout_q  <= '0;
         ack_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timeout_q  <= timeout_d;
         ack_pend_q <= ack_pend_d;
      end
   end

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Bench for mips_mc_sequencer: directed scenarios plus random traffic.
// Reference keeps each instruction as a list of steps chosen by opcode.
module tb_mips_mc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       reg_we;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       instr_done;
   logic       fault;
   logic [3:0] state;

   mips_mc_sequencer dut (
      .clk(clk), .rst(rst), .en(en),
      .opcode(opcode), .zero(zero),
      .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .reg_we(reg_we),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .instr_done(instr_done),
      .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   wire [20:0] ovec = {mem_req, mem_we, iord, ir_we,
                       pc_we, pc_src, reg_we, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b,
                       alu_op, instr_done, fault, state};

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_AD  = 6'h08;

   int checks = 0;
   int failures = 0;

   int  m_path[6];
   int  m_len;
   int  m_idx;
   int  m_wait;
   bit  m_idle;
   bit  m_fault;
   bit  m_pend;

   int h_st[$];
   int h_req[$];
   int h_io[$];
   int h_rw[$];
   int h_rd[$];
   int h_m2r[$];
   int h_pcw[$];
   int h_ps[$];
   int h_dn[$];
   int h_f[$];

   function automatic int m_code();
      if (m_idle) return 0;
      if (m_fault) return 15;
      return m_path[m_idx];
   endfunction

   function automatic bit is_mem(int c);
      return (c == 1) || (c == 4) || (c == 6);
   endfunction

   task automatic m_start();
      m_path[0] = 1;
      m_path[1] = 2;
      m_len = 2;
      m_idx = 0;
      m_wait = 0;
   endtask

   task automatic m_reset();
      m_idle = 1'b1;
      m_fault = 1'b0;
      m_pend = 1'b0;
      m_wait = 0;
      m_idx = 0;
      m_len = 0;
   endtask

   task automatic m_step(bit e, bit ak_in, logic [5:0] op);
      int  c;
      bit  ak;
      c = m_code();
      ak = ak_in | m_pend;
      if (!e) begin
         if (is_mem(c) && ak_in) m_pend = 1'b1;
         return;
      end
      m_pend = 1'b0;
      if (m_fault) return;
      if (m_idle) begin
         m_idle = 1'b0;
         m_start();
         return;
      end
      if (is_mem(c) && !ak) begin
         m_wait++;
         if (m_wait == 15) m_fault = 1'b1;
         return;
      end
      if (c == 2) begin
         case (op)
            OP_R:   begin m_path[2] = 7;  m_path[3] = 8;
                          m_len = 4; end
            OP_LW:  begin m_path[2] = 3;  m_path[3] = 4;
                          m_path[4] = 5;  m_len = 5; end
            OP_SW:  begin m_path[2] = 3;  m_path[3] = 6;
                          m_len = 4; end
            OP_BEQ: begin m_path[2] = 9;  m_len = 3; end
            OP_J:   begin m_path[2] = 10; m_len = 3; end
            OP_AD:  begin m_path[2] = 11; m_path[3] = 12;
                          m_len = 4; end
            default: begin m_fault = 1'b1; return; end
         endcase
      end
      m_wait = 0;
      m_idx++;
      if (m_idx == m_len) m_start();
   endtask

   function automatic logic [20:0] exp_vec(int c, bit e,
                                           bit ak, bit z);
      logic mr, mw, io, irw, pcw, rw, rd, m2r, a, dn, f;
      logic [1:0] ps, b, op;
      logic [3:0] st;
      {mr, mw, io, irw, pcw, rw, rd, m2r, a, dn, f} = '0;
      ps = 2'd0;
      b = 2'd0;
      op = 2'd0;
      st = 4'(c);
      case (c)
         1:  begin mr = 1; b = 2'd1;
                   irw = e && ak; pcw = e && ak; end
         2:  b = 2'd3;
         3:  begin a = 1; b = 2'd2; end
         4:  begin mr = 1; io = 1; end
         5:  begin rw = e; m2r = 1; dn = e; end
         6:  begin mr = 1; io = 1; mw = 1;
                   dn = e && ak; end
         7:  begin a = 1; op = 2'd2; end
         8:  begin rw = e; rd = 1; dn = e; end
         9:  begin a = 1; op = 2'd1; ps = 2'd1;
                   pcw = e && z; dn = e; end
         10: begin ps = 2'd2; pcw = e; dn = e; end
         11: begin a = 1; b = 2'd2; end
         12: begin rw = e; dn = e; end
         15: f = 1;
         default: f = 0;
      endcase
      return {mr, mw, io, irw, pcw, ps, rw, rd, m2r,
              a, b, op, dn, f, st};
   endfunction

   task automatic chk(string name, int act, int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, expv);
      end
   endtask

   task automatic clr();
      h_st.delete(); h_req.delete(); h_io.delete();
      h_rw.delete(); h_rd.delete(); h_m2r.delete();
      h_pcw.delete(); h_ps.delete(); h_dn.delete();
      h_f.delete();
   endtask

   task automatic cyc(bit e, bit ak, logic [5:0] op, bit z);
      logic [20:0] ev;
      @(negedge clk);
      en = e;
      mem_ack = ak;
      opcode = op;
      zero = z;
      #1;
      ev = exp_vec(m_code(), e, ak | m_pend, z);
      checks++;
      if (ovec !== ev) begin
         failures++;
         $display("FAIL cycle_outputs t=%0t: got %h expected %h",
                  $time, ovec, ev);
      end
      h_st.push_back(int'(state));
      h_req.push_back(int'(mem_req));
      h_io.push_back(int'(iord));
      h_rw.push_back(int'(reg_we));
      h_rd.push_back(int'(reg_dst));
      h_m2r.push_back(int'(mem_to_reg));
      h_pcw.push_back(int'(pc_we));
      h_ps.push_back(int'(pc_src));
      h_dn.push_back(int'(instr_done));
      h_f.push_back(int'(fault));
      @(posedge clk);
      m_step(e, ak, op);
   endtask

   task automatic do_reset(bit pre_req);
      @(negedge clk);
      #1;
      if (pre_req) chk("pre_reset_mem_req", int'(mem_req), 1);
      rst = 1'b0;
      en = 1'b0;
      mem_ack = 1'b0;
      #1;
      chk("reset_outputs_zero", int'(ovec), 0);
      m_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      int exp_r[6];
      int n;
      int fcyc;
      logic [5:0] ops[6];
      logic [5:0] op;
      bit e;
      bit a;
      bit z;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_AD};
      m_reset();

      do_reset(1'b0);
      clr();
      cyc(1, 0, OP_R, 0);
      cyc(1, 1, OP_R, 0);
      repeat (4) cyc(1, 0, OP_R, 0);
      exp_r = '{0, 1, 2, 7, 8, 1};
      for (int i = 0; i < 6; i++)
         chk($sformatf("rtype_state_%0d", i), h_st[i], exp_r[i]);
      chk("rtype_rwb_reg_we", h_rw[4], 1);
      chk("rtype_rwb_reg_dst", h_rd[4], 1);
      n = 0;
      foreach (h_dn[i]) n += h_dn[i];
      chk("rtype_done_count", n, 1);

      clr();
      cyc(1, 1, OP_LW, 0);
      repeat (5) cyc(1, 0, OP_LW, 0);
      cyc(1, 1, OP_LW, 0);
      cyc(1, 0, OP_LW, 0);
      n = 0;
      for (int i = 3; i < 7; i++) n += h_req[i] + h_io[i];
      chk("lw_memrd_req_iord", n, 8);
      chk("lw_memadr_no_req", h_req[2], 0);
      chk("lw_memwb_no_req", h_req[7], 0);
      chk("lw_memwb_state", h_st[7], 5);
      chk("lw_memwb_reg_we", h_rw[7], 1);
      chk("lw_memwb_mem_to_reg", h_m2r[7], 1);

      clr();
      cyc(1, 1, OP_BEQ, 1);
      repeat (2) cyc(1, 0, OP_BEQ, 1);
      cyc(1, 1, OP_BEQ, 0);
      repeat (2) cyc(1, 0, OP_BEQ, 0);
      cyc(1, 0, OP_BEQ, 0);
      chk("beq1_branch_state", h_st[2], 9);
      chk("beq1_pc_we", h_pcw[2], 1);
      chk("beq1_pc_src", h_ps[2], 1);
      chk("beq1_three_cycles", h_st[3], 1);
      chk("beq0_branch_state", h_st[5], 9);
      chk("beq0_pc_we", h_pcw[5], 0);
      chk("beq0_three_cycles", h_st[6], 1);

      clr();
      cyc(1, 1, OP_SW, 0);
      repeat (17) cyc(1, 0, OP_SW, 0);
      repeat (4) cyc(1, 1, OP_SW, 0);
      chk("sw_first_memwr", h_st[3], 6);
      chk("sw_last_memwr", h_st[17], 6);
      chk("sw_timeout_state", h_st[18], 15);
      chk("sw_timeout_no_req", h_req[18], 0);
      chk("sw_fault_sticky_state", h_st[21], 15);
      chk("sw_fault_sticky_flag", h_f[21], 1);
      do_reset(1'b0);

      clr();
      cyc(1, 0, OP_R, 0);
      cyc(0, 1, OP_R, 0);
      cyc(0, 0, OP_R, 0);
      cyc(1, 0, OP_R, 0);
      cyc(1, 0, 6'h3f, 0);
      cyc(1, 0, 6'h3f, 0);
      chk("freeze_state_a", h_st[1], 1);
      chk("freeze_state_b", h_st[2], 1);
      chk("freeze_req_held", h_req[1] + h_req[2], 2);
      chk("freeze_pc_we_gated", h_pcw[1], 0);
      chk("freeze_pend_pc_we", h_pcw[3], 1);
      chk("freeze_to_decode", h_st[4], 2);
      chk("illegal_to_fault", h_st[5], 15);

      do_reset(1'b0);
      cyc(1, 0, OP_LW, 0);
      cyc(1, 1, OP_LW, 0);
      repeat (3) cyc(1, 0, OP_LW, 0);
      do_reset(1'b1);

      fcyc = 0;
      op = OP_R;
      for (int i = 0; i < 4000; i++) begin
         if (m_fault) begin
            fcyc++;
            if (fcyc > 4) begin
               do_reset(1'b0);
               fcyc = 0;
            end
         end else if ($urandom_range(599) == 0) begin
            do_reset(1'b0);
         end
         if (m_code() == 1) begin
            if ($urandom_range(19) == 0)
               op = 6'($urandom);
            else
               op = ops[$urandom_range(5)];
         end
         e = ($urandom_range(3) != 0);
         a = ($urandom_range(9) < 3);
         z = 1'($urandom_range(1));
         cyc(e, a, op, z);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
